// File: rtl/mesm6_pkg.sv
// Shared definitions for the MESM-6 instruction fetch path.
//   fetch_state_t  : states of the prefetch buffer's ibus fetch FSM
//   MESM6_OPCODE_W : opcode width of the native 48-bit MESM-6 word
//   select_half    : picks the left (upper) or right (lower) opcode of a word
package mesm6_pkg;

    typedef enum logic [1:0] {
        FS_IDLE    = 2'd0,  // no bus request outstanding
        FS_FETCH   = 2'd1,  // request outstanding, data will be buffered
        FS_DISCARD = 2'd2   // request outstanding, data belongs to a flushed stream
    } fetch_state_t;

    localparam int MESM6_WORD_W   = 48;
    localparam int MESM6_OPCODE_W = MESM6_WORD_W / 2;

    // Widest instruction word the half-select helper supports.
    localparam int HALF_SEL_MAX_W = 64;

    // Returns the upper half of a word_w-bit word when right = 0 and the
    // lower half when right = 1. The word arrives zero-extended to
    // HALF_SEL_MAX_W; the caller truncates the result to word_w/2 bits.
    function automatic logic [HALF_SEL_MAX_W/2-1:0] select_half(
        input logic [HALF_SEL_MAX_W-1:0] word,
        input int unsigned               word_w,
        input logic                      right
    );
        logic [HALF_SEL_MAX_W-1:0] mask;
        logic [HALF_SEL_MAX_W-1:0] shifted;
        mask    = (HALF_SEL_MAX_W'(1) << (word_w / 2)) - HALF_SEL_MAX_W'(1);
        shifted = right ? word : (word >> (word_w / 2));
        return (HALF_SEL_MAX_W/2)'(shifted & mask);
    endfunction

endpackage

// File: rtl/mesm6_fifo_mem.sv
// DEPTH-entry register-array FIFO storage with wrapping read/write pointers.
// Occupancy is tracked by the owner; this block only stores and addresses.
//   clk, reset_n : clock, asynchronous active-low reset (pointers only)
//   wr_en        : write wr_data at the tail and advance the tail
//   rd_adv       : advance the head past the current entry
//   flush        : return both pointers to entry 0 (overrides wr_en/rd_adv)
//   rd_data      : entry at the head, combinational
module mesm6_fifo_mem #(
    parameter int DEPTH   = 4,
    parameter int ENTRY_W = 63
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               wr_en,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic               rd_adv,
    input  logic               flush,
    output logic [ENTRY_W-1:0] rd_data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            // DEPTH is a power of two, so the natural pointer wrap is modulo DEPTH.
            if (wr_en)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (rd_adv) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: the storage array has no reset; an entry is never read before it
    // is written because the owner's count gates validity.
    always_ff @(posedge clk) begin
        if (wr_en && !flush) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/mesm6_fetch_buffer.sv
// Instruction prefetch buffer between the MESM-6 front end and the ibus.
// Holds up to DEPTH 48-bit words (two opcodes each) tagged with their word
// address, prefetches sequential words, and flushes on cpu_jump.
//   clk, reset_n : clock, asynchronous active-low reset
//   cpu_pc       : half-word PC; bit 0 selects left (0) / right (1) opcode
//   cpu_pop      : core is done with the head word
//   cpu_jump     : flush and refetch from cpu_pc[ADDR_W:1]
//   cpu_valid    : head word present and tagged with cpu_pc[ADDR_W:1]
//   cpu_opcode   : selected opcode of the head word
//   count        : number of buffered words
//   ibus_fetch/ibus_addr : registered fetch request, stable until ibus_done
//   ibus_input/ibus_done : returned word and completion strobe
module mesm6_fetch_buffer
    import mesm6_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int ADDR_W     = 15,
    parameter int WORD_W     = 48,
    parameter int PREFETCH   = 1,
    parameter int RESET_ADDR = 0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [ADDR_W:0]          cpu_pc,
    input  logic                     cpu_pop,
    input  logic                     cpu_jump,
    output logic                     cpu_valid,
    output logic [WORD_W/2-1:0]      cpu_opcode,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ibus_fetch,
    output logic [ADDR_W-1:0]        ibus_addr,
    input  logic [WORD_W-1:0]        ibus_input,
    input  logic                     ibus_done
);

    localparam int OPC_W   = WORD_W / 2;
    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = ADDR_W + WORD_W;

    localparam logic [CNT_W-1:0]  DEPTH_C      = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] RESET_ADDR_C = ADDR_W'(RESET_ADDR);

    fetch_state_t       state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ADDR_W-1:0]  fptr_q, fptr_d;
    logic               ibus_fetch_q, ibus_fetch_d;
    logic [ADDR_W-1:0]  ibus_addr_q, ibus_addr_d;

    logic               done_edge;
    logic               wr_en;
    logic               pop_en;
    logic [CNT_W-1:0]   cnt_after;
    logic               issue_ok;
    logic               launch;
    logic [ADDR_W-1:0]  target;
    logic [ENTRY_W-1:0] head_entry;
    logic [ADDR_W-1:0]  head_addr;
    logic [WORD_W-1:0]  head_data;

    assign target    = cpu_pc[ADDR_W:1];
    assign done_edge = ibus_fetch_q && ibus_done;

    // Returned data is only kept in FETCH; a jump on the same edge drops it.
    assign wr_en  = (state_q == FS_FETCH) && done_edge && !cpu_jump;
    // Jump wins over pop; popping an empty buffer is a no-op.
    assign pop_en = cpu_pop && (count_q != '0) && !cpu_jump;

    // Occupancy after this edge's write and pop. No fetch is outstanding once
    // a new one would be launched, so comparing against DEPTH here already
    // accounts for the in-flight word and the buffer can never overflow.
    assign cnt_after = count_q + CNT_W'(wr_en) - CNT_W'(pop_en);
    assign issue_ok  = (PREFETCH != 0) ? (cnt_after < DEPTH_C) : (cnt_after == '0);

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FS_IDLE: begin
                if (cpu_jump || issue_ok) state_d = FS_FETCH;
            end
            FS_FETCH: begin
                if (cpu_jump) begin
                    // An undone request cannot be withdrawn; ride it out in DISCARD.
                    state_d = done_edge ? FS_FETCH : FS_DISCARD;
                end else if (done_edge) begin
                    state_d = issue_ok ? FS_FETCH : FS_IDLE;
                end
            end
            FS_DISCARD: begin
                if (done_edge) state_d = FS_FETCH;
            end
            default: state_d = FS_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- outputs / datapath
    always_comb begin
        fptr_d  = fptr_q;
        count_d = cnt_after;
        if (cpu_jump) begin
            fptr_d  = target;
            count_d = '0;
        end else if (wr_en) begin
            fptr_d = fptr_q + ADDR_W'(1);
        end

        // A new request starts from IDLE, or back-to-back when the current one
        // completes; in every case it targets the updated fetch pointer.
        launch       = (state_d == FS_FETCH) && ((state_q == FS_IDLE) || done_edge);
        ibus_fetch_d = (state_d != FS_IDLE);
        ibus_addr_d  = launch ? fptr_d : ibus_addr_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q      <= '0;
            fptr_q       <= RESET_ADDR_C;
            ibus_fetch_q <= 1'b0;
            ibus_addr_q  <= RESET_ADDR_C;
        end else begin
            count_q      <= count_d;
            fptr_q       <= fptr_d;
            ibus_fetch_q <= ibus_fetch_d;
            ibus_addr_q  <= ibus_addr_d;
        end
    end

    // ---------------------------------------------------------------- storage
    mesm6_fifo_mem #(
        .DEPTH   (DEPTH),
        .ENTRY_W (ENTRY_W)
    ) u_fifo_mem (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_en),
        .wr_data ({ibus_addr_q, ibus_input}),
        .rd_adv  (pop_en),
        .flush   (cpu_jump),
        .rd_data (head_entry)
    );

    assign head_addr = head_entry[ENTRY_W-1:WORD_W];
    assign head_data = head_entry[WORD_W-1:0];

    assign cpu_valid  = (count_q != '0) && (head_addr == target);
    assign cpu_opcode = OPC_W'(select_half(HALF_SEL_MAX_W'(head_data), 32'(WORD_W), cpu_pc[0]));

    assign count      = count_q;
    assign ibus_fetch = ibus_fetch_q;
    assign ibus_addr  = ibus_addr_q;

endmodule

// File: tb/tb_mesm6_fetch_buffer.sv
// Directed self-checking bench for mesm6_fetch_buffer. Two instances share
// clock and reset: u_dut prefetches (PREFETCH=1), u_dut_dm runs in demand
// mode (PREFETCH=0). The ibus memory returns mem_word(addr) in zero wait
// states whenever the bench holds ibus_done high.
module tb_mesm6_fetch_buffer;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 15;
    localparam int WORD_W = 48;
    localparam int OPC_W  = WORD_W / 2;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    // prefetching instance
    logic [ADDR_W:0]     pc;
    logic                pop, jump, done;
    logic                valid;
    logic [OPC_W-1:0]    opcode;
    logic [CNT_W-1:0]    cnt;
    logic                fetch;
    logic [ADDR_W-1:0]   addr;
    logic [WORD_W-1:0]   rdata;

    // demand-mode instance
    logic [ADDR_W:0]     dm_pc;
    logic                dm_pop, dm_jump, dm_done;
    logic                dm_valid;
    logic [OPC_W-1:0]    dm_opcode;
    logic [CNT_W-1:0]    dm_cnt;
    logic                dm_fetch;
    logic [ADDR_W-1:0]   dm_addr;
    logic [WORD_W-1:0]   dm_rdata;

    // Word 0 is the documented example; others carry the address in the left
    // opcode and {0o377, addr ^ 0o12345} in the right opcode.
    function automatic logic [WORD_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        if (a == '0) return 48'o0010000002200000;
        return {9'd0, a, 9'o377, a ^ 15'o12345};
    endfunction

    assign rdata    = mem_word(addr);
    assign dm_rdata = mem_word(dm_addr);

    mesm6_fetch_buffer #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .WORD_W(WORD_W), .PREFETCH(1), .RESET_ADDR(0)
    ) u_dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_pc(pc), .cpu_pop(pop), .cpu_jump(jump),
        .cpu_valid(valid), .cpu_opcode(opcode), .count(cnt),
        .ibus_fetch(fetch), .ibus_addr(addr), .ibus_input(rdata), .ibus_done(done)
    );

    mesm6_fetch_buffer #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .WORD_W(WORD_W), .PREFETCH(0), .RESET_ADDR(0)
    ) u_dut_dm (
        .clk(clk), .reset_n(reset_n),
        .cpu_pc(dm_pc), .cpu_pop(dm_pop), .cpu_jump(dm_jump),
        .cpu_valid(dm_valid), .cpu_opcode(dm_opcode), .count(dm_cnt),
        .ibus_fetch(dm_fetch), .ibus_addr(dm_addr), .ibus_input(dm_rdata), .ibus_done(dm_done)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        pc = '0; pop = 1'b0; jump = 1'b0; done = 1'b1;
        dm_pc = '0; dm_pop = 1'b0; dm_jump = 1'b0; dm_done = 1'b1;

        #12;
        check("rst_count", cnt, 0);
        check("rst_fetch", fetch, 0);
        check("rst_addr", addr, 0);
        check("rst_valid", valid, 0);
        check("rst_dm_fetch", dm_fetch, 0);

        @(negedge clk);
        reset_n = 1'b1;

        // Sequential fill with ibus_done tied high.
        tick;
        check("fill_addr0", addr, 0);
        check("fill_fetch0", fetch, 1);
        check("fill_count0", cnt, 0);
        check("dm_first_fetch", dm_fetch, 1);
        tick;
        check("fill_addr1", addr, 1);
        check("fill_count1", cnt, 1);
        check("w0_valid_left", valid, 1);
        check("w0_op_left", opcode, 24'o00100000);
        check("dm_idle_count1", dm_cnt, 1);
        check("dm_idle_fetch", dm_fetch, 0);
        dm_pop = 1'b1;
        tick;
        check("fill_addr2", addr, 2);
        check("dm_pop_count0", dm_cnt, 0);
        check("dm_refetch", dm_fetch, 1);
        check("dm_refetch_addr", dm_addr, 1);
        dm_pop = 1'b0;
        tick;
        check("fill_addr3", addr, 3);
        check("dm_count_back1", dm_cnt, 1);
        check("dm_fetch_drop", dm_fetch, 0);
        tick;
        check("full_fetch_drop", fetch, 0);
        check("full_count", cnt, 4);

        // Opcode select on the head word.
        pc = 16'd1;
        #1;
        check("w0_op_right", opcode, 24'o02200000);
        check("w0_valid_right", valid, 1);
        tick;
        check("w0_op_right_hold", opcode, 24'o02200000);
        check("full_idle_count", cnt, 4);
        check("full_idle_fetch", fetch, 0);

        // Pop every cycle from full with zero-wait memory.
        pop = 1'b1;
        tick;
        check("stream_addr4", addr, 4);
        check("stream_fetch4", fetch, 1);
        check("stream_count_a", cnt, 3);
        tick;
        check("stream_addr5", addr, 5);
        check("stream_count_b", cnt, 3);
        tick;
        check("stream_addr6", addr, 6);
        check("stream_count_c", cnt, 3);
        pop = 1'b0;
        tick;
        check("refill_count", cnt, 4);
        check("refill_fetch", fetch, 0);
        pc = 16'd6;
        #1;
        check("w3_valid", valid, 1);
        check("w3_op_left", opcode, 24'd3);
        pc = 16'd7;
        #1;
        check("w3_op_right", opcode, 24'o37712346);

        // Jump while idle to word 5, keep it outstanding, then redirect.
        done = 1'b0;
        jump = 1'b1;
        pc   = 16'd10;
        tick;
        check("jmp_idle_addr", addr, 5);
        check("jmp_idle_count", cnt, 0);
        check("jmp_idle_valid", valid, 0);
        jump = 1'b0;
        tick;
        check("wait_addr5_a", addr, 5);
        tick;
        check("wait_addr5_b", addr, 5);
        jump = 1'b1;
        pc   = 16'o200;
        tick;
        check("discard_addr_hold", addr, 5);
        check("discard_fetch_hold", fetch, 1);
        check("discard_count", cnt, 0);
        jump = 1'b0;
        tick;
        check("discard_addr_hold2", addr, 5);
        done = 1'b1;
        tick;
        check("redirect_addr", addr, 15'o100);
        check("redirect_count0", cnt, 0);
        check("redirect_fetch", fetch, 1);
        done = 1'b0;
        tick;
        check("redirect_wait_count", cnt, 0);
        check("redirect_wait_valid", valid, 0);
        done = 1'b1;
        tick;
        check("redirect_count1", cnt, 1);
        check("redirect_next_addr", addr, 15'o101);
        check("w100_valid", valid, 1);
        check("w100_op_left", opcode, 24'o100);
        pc = 16'o201;
        #1;
        check("w100_op_right", opcode, 24'o37712245);

        // Jump on a completing edge, then wrap of the fetch pointer.
        jump = 1'b1;
        pc   = 16'o177776;
        tick;
        check("wrap_jump_addr", addr, 15'o77777);
        check("wrap_jump_count", cnt, 0);
        jump = 1'b0;
        tick;
        check("wrap_addr0", addr, 0);
        check("wrap_count1", cnt, 1);
        check("wrap_valid", valid, 1);
        check("w77777_op_left", opcode, 24'o77777);
        pc = 16'o177777;
        #1;
        check("w77777_op_right", opcode, 24'o37765432);

        // Asynchronous reset in the middle of an outstanding fetch.
        done = 1'b0;
        tick;
        check("pre_areset_fetch", fetch, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("areset_fetch", fetch, 0);
        check("areset_count", cnt, 0);
        check("areset_valid", valid, 0);
        check("areset_dm_count", dm_cnt, 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick;
        check("post_areset_fetch", fetch, 1);
        check("post_areset_addr", addr, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
